// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared widths, ALU op-codes and op-code legality helper
package alu_pkg;

    localparam int DATA_W = 32;
    localparam int CTRL_W = 3;

    localparam logic [CTRL_W-1:0] ALU_ADD = 3'b000;
    localparam logic [CTRL_W-1:0] ALU_SUB = 3'b001;
    localparam logic [CTRL_W-1:0] ALU_AND = 3'b010;
    localparam logic [CTRL_W-1:0] ALU_OR  = 3'b011;
    localparam logic [CTRL_W-1:0] ALU_XOR = 3'b100;
    localparam logic [CTRL_W-1:0] ALU_SLT = 3'b101;

    function automatic logic is_illegal_op(input logic [CTRL_W-1:0] op);
        return (op > ALU_SLT);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - 2-way round-robin picker owning the last-grant pointer
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] elig,
    output logic [1:0] grant
);

    logic last_grant;

    always_comb begin
        grant = elig;
        if (elig == 2'b11) begin
            grant = last_grant ? 2'b01 : 2'b10;
        end
    end

    // Reset to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (|grant) begin
            last_grant <= grant[1];
        end
    end

endmodule

// File: rtl/alu_share_arb.sv
// rtl/alu_share_arb.sv - one ALU shared by two requesters with per-requester response buffers
module alu_share_arb
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [CTRL_W-1:0] req0_ctrl,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [CTRL_W-1:0] req1_ctrl,
    output logic              resp0_valid,
    input  logic              resp0_ready,
    output logic [DATA_W-1:0] resp0_result,
    output logic              resp0_zero,
    output logic              resp0_err,
    output logic              resp1_valid,
    input  logic              resp1_ready,
    output logic [DATA_W-1:0] resp1_result,
    output logic              resp1_zero,
    output logic              resp1_err
);

    logic [1:0]        elig;
    logic [1:0]        grant;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [CTRL_W-1:0] op_ctrl;
    logic [DATA_W-1:0] alu_res;
    logic              alu_err;
    logic              alu_zero;

    // A requester may issue when its buffer is empty or being drained this cycle.
    assign elig[0] = req0_valid & (~resp0_valid | resp0_ready);
    assign elig[1] = req1_valid & (~resp1_valid | resp1_ready);

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .elig  (elig),
        .grant (grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    assign op_a    = grant[1] ? req1_a    : req0_a;
    assign op_b    = grant[1] ? req1_b    : req0_b;
    assign op_ctrl = grant[1] ? req1_ctrl : req0_ctrl;

    always_comb begin
        alu_res = '0;
        alu_err = is_illegal_op(op_ctrl);
        case (op_ctrl)
            ALU_ADD: alu_res = op_a + op_b;
            ALU_SUB: alu_res = op_a - op_b;
            ALU_AND: alu_res = op_a & op_b;
            ALU_OR:  alu_res = op_a | op_b;
            ALU_XOR: alu_res = op_a ^ op_b;
            ALU_SLT: alu_res = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            default: alu_res = '0;
        endcase
    end

    // An illegal op reports a zero result but must not look like a genuine zero.
    assign alu_zero = (alu_res == '0) & ~alu_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp0_valid  <= 1'b0;
            resp0_result <= '0;
            resp0_zero   <= 1'b0;
            resp0_err    <= 1'b0;
        end else if (grant[0]) begin
            resp0_valid  <= 1'b1;
            resp0_result <= alu_res;
            resp0_zero   <= alu_zero;
            resp0_err    <= alu_err;
        end else if (resp0_ready) begin
            resp0_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp1_valid  <= 1'b0;
            resp1_result <= '0;
            resp1_zero   <= 1'b0;
            resp1_err    <= 1'b0;
        end else if (grant[1]) begin
            resp1_valid  <= 1'b1;
            resp1_result <= alu_res;
            resp1_zero   <= alu_zero;
            resp1_err    <= alu_err;
        end else if (resp1_ready) begin
            resp1_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_share_arb.sv
// tb/tb_alu_share_arb.sv - self-checking bench for alu_share_arb with per-requester scoreboards
module tb_alu_share_arb;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [2:0]  req0_ctrl = '0, req1_ctrl = '0;
    logic        resp0_valid, resp1_valid;
    logic        resp0_ready = 1'b1, resp1_ready = 1'b1;
    logic [31:0] resp0_result, resp1_result;
    logic        resp0_zero, resp1_zero, resp0_err, resp1_err;

    typedef struct packed {
        logic [31:0] result;
        logic        zero;
        logic        err;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    alu_share_arb dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
        .resp0_result(resp0_result), .resp0_zero(resp0_zero), .resp0_err(resp0_err),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
        .resp1_result(resp1_result), .resp1_zero(resp1_zero), .resp1_err(resp1_err)
    );

    function automatic exp_t model(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.result = '0;
        e.err    = 1'b0;
        case (c)
            3'b000:  e.result = a + b;
            3'b001:  e.result = a - b;
            3'b010:  e.result = a & b;
            3'b011:  e.result = a | b;
            3'b100:  e.result = a ^ b;
            3'b101:  e.result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: e.err = 1'b1;
        endcase
        e.zero = !e.err && (e.result == 32'd0);
        return e;
    endfunction

    // Consumption is popped before the same cycle's new request is pushed.
    always @(negedge clk) begin
        if (rst_n) begin
            if (resp0_valid && resp0_ready) begin
                total++;
                if (q0.size() == 0) begin
                    bad++;
                    $display("FAIL resp0_unexpected got=%h expected no response", resp0_result);
                end else begin
                    e0 = q0.pop_front();
                    if ({resp0_result, resp0_zero, resp0_err} !== e0) begin
                        bad++;
                        $display("FAIL resp0_data got=%h/%b/%b expected=%h/%b/%b",
                                 resp0_result, resp0_zero, resp0_err, e0.result, e0.zero, e0.err);
                    end
                end
            end
            if (resp1_valid && resp1_ready) begin
                total++;
                if (q1.size() == 0) begin
                    bad++;
                    $display("FAIL resp1_unexpected got=%h expected no response", resp1_result);
                end else begin
                    e1 = q1.pop_front();
                    if ({resp1_result, resp1_zero, resp1_err} !== e1) begin
                        bad++;
                        $display("FAIL resp1_data got=%h/%b/%b expected=%h/%b/%b",
                                 resp1_result, resp1_zero, resp1_err, e1.result, e1.zero, e1.err);
                    end
                end
            end
            if (req0_valid && req0_ready) q0.push_back(model(req0_ctrl, req0_a, req0_b));
            if (req1_valid && req1_ready) q1.push_back(model(req1_ctrl, req1_a, req1_b));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req0(input logic v, input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        req0_valid = v; req0_ctrl = c; req0_a = a; req0_b = b;
    endtask

    task automatic set_req1(input logic v, input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        req1_valid = v; req1_ctrl = c; req1_a = a; req1_b = b;
    endtask

    task automatic test_reset();
        resp0_ready = 1'b0;
        set_req0(1'b1, ALU_ADD, 32'd1, 32'd2);
        cyc();
        set_req0(1'b0, ALU_ADD, 32'd0, 32'd0);
        total++;
        if (resp0_valid !== 1'b1) begin
            bad++; $display("FAIL pre_reset_valid got=%b expected=1", resp0_valid);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({resp0_valid, resp1_valid, resp0_err, resp1_err, resp0_zero, resp1_zero} !== 6'b0 ||
            resp0_result !== 32'd0 || resp1_result !== 32'd0) begin
            bad++;
            $display("FAIL reset_state got valid=%b%b err=%b%b zero=%b%b r0=%h r1=%h expected all 0",
                     resp0_valid, resp1_valid, resp0_err, resp1_err, resp0_zero, resp1_zero,
                     resp0_result, resp1_result);
        end
        q0.delete();
        q1.delete();
        resp0_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        set_req0(1'b1, ALU_ADD, 32'd10, 32'd20);
        set_req1(1'b1, ALU_XOR, 32'd5, 32'd3);
        @(negedge clk);
        total++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            bad++; $display("FAIL first_grant got r0=%b r1=%b expected r0=1 r1=0", req0_ready, req1_ready);
        end
        cyc();
        @(negedge clk);
        total++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            bad++; $display("FAIL second_grant got r0=%b r1=%b expected r0=0 r1=1", req0_ready, req1_ready);
        end
        cyc();
        set_req0(1'b0, ALU_ADD, 32'd0, 32'd0);
        set_req1(1'b0, ALU_ADD, 32'd0, 32'd0);
        cyc();
    endtask

    task automatic test_round_robin();
        set_req0(1'b1, ALU_SLT, 32'hFFFF_FFFF, 32'd1);
        set_req1(1'b1, ALU_SUB, 32'd3, 32'd3);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            total++;
            if (req0_ready !== (i % 2 == 0) || req1_ready !== (i % 2 == 1)) begin
                bad++;
                $display("FAIL rr_grant_%0d got r0=%b r1=%b expected r0=%0d r1=%0d",
                         i, req0_ready, req1_ready, (i % 2 == 0), (i % 2 == 1));
            end
            cyc();
        end
        set_req0(1'b0, ALU_ADD, 32'd0, 32'd0);
        set_req1(1'b0, ALU_ADD, 32'd0, 32'd0);
        total++;
        if (resp1_valid !== 1'b1 || resp1_zero !== 1'b1 || resp1_result !== 32'd0) begin
            bad++;
            $display("FAIL rr_sub_zero got v=%b z=%b r=%h expected v=1 z=1 r=0", resp1_valid, resp1_zero, resp1_result);
        end
        total++;
        if (resp0_result !== 32'd1) begin
            bad++; $display("FAIL rr_slt got=%h expected=1", resp0_result);
        end
        cyc();
    endtask

    task automatic test_add_single();
        set_req0(1'b1, ALU_ADD, 32'd5, 32'd7);
        @(negedge clk);
        total++;
        if (req0_ready !== 1'b1) begin
            bad++; $display("FAIL add_ready got=%b expected=1", req0_ready);
        end
        cyc();
        set_req0(1'b0, ALU_ADD, 32'd0, 32'd0);
        total++;
        if (resp0_valid !== 1'b1 || resp0_result !== 32'd12 || resp0_zero !== 1'b0) begin
            bad++;
            $display("FAIL add_resp got v=%b r=%h z=%b expected v=1 r=0000000c z=0", resp0_valid, resp0_result, resp0_zero);
        end
        cyc();
    endtask

    task automatic test_backpressure();
        resp1_ready = 1'b0;
        set_req1(1'b1, ALU_AND, 32'h0000_FF00, 32'h0000_0FF0);
        cyc();
        set_req1(1'b1, ALU_OR, 32'd1, 32'd2);
        for (int i = 0; i < 3; i++) begin
            set_req0(1'b1, ALU_ADD, i, 32'd100);
            @(negedge clk);
            total++;
            if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_blocked_%0d got r0=%b r1=%b expected r0=1 r1=0", i, req0_ready, req1_ready);
            end
            cyc();
        end
        resp1_ready = 1'b1;
        @(negedge clk);
        total++;
        if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_release got r0=%b r1=%b expected r0=0 r1=1", req0_ready, req1_ready);
        end
        cyc();
        set_req0(1'b0, ALU_ADD, 32'd0, 32'd0);
        set_req1(1'b0, ALU_ADD, 32'd0, 32'd0);
        cyc();
        cyc();
    endtask

    task automatic test_back_to_back();
        logic [2:0]  ops [4];
        logic [31:0] as  [4];
        logic [31:0] bs  [4];
        ops = '{ALU_ADD, ALU_SUB, ALU_XOR, ALU_SLT};
        as  = '{32'd100, 32'd0, 32'h0000_AAAA, 32'd5};
        bs  = '{32'hFFFF_FFFF, 32'd1, 32'h0000_5555, 32'hFFFF_FFFB};
        for (int i = 0; i < 4; i++) begin
            set_req0(1'b1, ops[i], as[i], bs[i]);
            if (i > 0) begin
                total++;
                if (resp0_valid !== 1'b1) begin
                    bad++; $display("FAIL b2b_bubble_%0d got valid=%b expected=1", i, resp0_valid);
                end
            end
            @(negedge clk);
            total++;
            if (req0_ready !== 1'b1) begin
                bad++; $display("FAIL b2b_ready_%0d got=%b expected=1", i, req0_ready);
            end
            cyc();
        end
        set_req0(1'b0, ALU_ADD, 32'd0, 32'd0);
        total++;
        if (resp0_valid !== 1'b1 || resp0_result !== 32'd0 || resp0_zero !== 1'b1) begin
            bad++;
            $display("FAIL b2b_last got v=%b r=%h z=%b expected v=1 r=0 z=1", resp0_valid, resp0_result, resp0_zero);
        end
        cyc();
    endtask

    task automatic test_illegal();
        set_req1(1'b1, 3'b111, 32'd9, 32'd4);
        @(negedge clk);
        total++;
        if (req1_ready !== 1'b1) begin
            bad++; $display("FAIL illegal_ready got=%b expected=1", req1_ready);
        end
        cyc();
        set_req1(1'b1, ALU_OR, 32'h0000_00F0, 32'h0000_000F);
        total++;
        if (resp1_err !== 1'b1 || resp1_result !== 32'd0 || resp1_zero !== 1'b0) begin
            bad++;
            $display("FAIL illegal_resp got e=%b r=%h z=%b expected e=1 r=0 z=0", resp1_err, resp1_result, resp1_zero);
        end
        cyc();
        set_req1(1'b0, ALU_ADD, 32'd0, 32'd0);
        total++;
        if (resp1_err !== 1'b0 || resp1_result !== 32'h0000_00FF || resp1_zero !== 1'b0) begin
            bad++;
            $display("FAIL or_after_illegal got e=%b r=%h z=%b expected e=0 r=000000ff z=0", resp1_err, resp1_result, resp1_zero);
        end
        cyc();
    endtask

    initial begin
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();
        test_reset();
        test_round_robin();
        test_add_single();
        test_backpressure();
        test_back_to_back();
        test_illegal();
        repeat (3) cyc();
        total++;
        if (q0.size() != 0 || q1.size() != 0) begin
            bad++; $display("FAIL outstanding got q0=%0d q1=%0d expected 0/0", q0.size(), q1.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
